// File: rtl/pll_reset_pkg.sv
// Shared state encoding, default parameters and width helpers for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_STABLE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_RETRY  = 3'd4
    } state_e;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_LOCK_STABLE = 1024;
    localparam int unsigned DEF_RST_HOLD    = 16;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_TIMEOUT     = 65536;
    localparam int unsigned DEF_RETRY_PULSE = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = 32'(i) + 32'd1;
            end
        end
        return res;
    endfunction

    // Width of a counter that must hold 0 .. n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 32'd1 : clog2(n);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage flop synchronizer for a single asynchronous bit, clearing to 0 on reset.
// Latency: STAGES clocks. Backpressure: none, samples every cycle.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Sequenced reset for the PLL clock domain: release after qualified lock, immediate reassert on loss.
// Latency: release SYNC_STAGES+LOCK_STABLE+RST_HOLD-1 clocks after lock, assert SYNC_STAGES clocks after loss.
// Backpressure: none. Optional re-lock request pulse under PLL_RESET_SEQ_RETRY_EN.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int unsigned RST_HOLD    = DEF_RST_HOLD,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned RETRY_PULSE = DEF_RETRY_PULSE
) (
    input  logic             clock_in,
    input  logic             rst_in,
    input  logic             locked_in,
    output logic             rst_out,
    output logic             rst_n_out,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             pll_retry_out
);

    if (SYNC_STAGES < 2 || LOCK_STABLE < 1 || RST_HOLD < 1 || CNT_W < 1 ||
        TIMEOUT < 1 || RETRY_PULSE < 1) begin : g_bad_param
        $error("pll_reset_seq: illegal parameter value");
    end

    localparam int unsigned SW = cnt_width(LOCK_STABLE);
    localparam int unsigned HW = cnt_width(RST_HOLD);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD - 1);

    logic lock_s;

    state_e           state_q, state_d;
    logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             rst_q, rst_d;
    logic             rst_n_q, rst_n_d;
    logic             ready_q, ready_d;

`ifdef PLL_RESET_SEQ_RETRY_EN
    localparam int unsigned TW = cnt_width(TIMEOUT);
    localparam int unsigned PW = cnt_width(RETRY_PULSE);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RETRY_PULSE - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          retry_q, retry_d;
`endif

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clock_in),
        .rst_n(rst_in),
        .d    (locked_in),
        .q    (lock_s)
    );

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        rst_d        = rst_q;
        ready_d      = ready_q;
`ifdef PLL_RESET_SEQ_RETRY_EN
        tmo_cnt_d    = tmo_cnt_q;
        pulse_cnt_d  = pulse_cnt_q;
        retry_d      = retry_q;
`endif
        case (state_q)
            ST_WAIT: begin
                rst_d   = 1'b1;
                ready_d = 1'b0;
                // The cycle that first sees lock_s high is already the first qualified lock cycle.
                if (lock_s) begin
`ifdef PLL_RESET_SEQ_RETRY_EN
                    tmo_cnt_d = '0;
`endif
                    if (LOCK_STABLE == 1) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        state_d      = ST_STABLE;
                        stable_cnt_d = SW'(1);
                    end
                end
`ifdef PLL_RESET_SEQ_RETRY_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_RETRY;
                    tmo_cnt_d   = '0;
                    pulse_cnt_d = '0;
                    retry_d     = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d      = ST_WAIT;
                    stable_cnt_d = '0;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    stable_cnt_d = stable_cnt_q + SW'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    rst_d   = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    rst_d   = 1'b1;
                    ready_d = 1'b0;
                    if (loss_cnt_q != {CNT_W{1'b1}}) begin
                        loss_cnt_d = loss_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef PLL_RESET_SEQ_RETRY_EN
            ST_RETRY: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d   = ST_WAIT;
                    retry_d   = 1'b0;
                    tmo_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_WAIT;
                rst_d   = 1'b1;
                ready_d = 1'b0;
            end
        endcase
        rst_n_d = ~rst_d;
    end

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_WAIT;
            stable_cnt_q <= '0;
            hold_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            rst_q        <= 1'b1;
            rst_n_q      <= 1'b0;
            ready_q      <= 1'b0;
`ifdef PLL_RESET_SEQ_RETRY_EN
            tmo_cnt_q    <= '0;
            pulse_cnt_q  <= '0;
            retry_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            rst_q        <= rst_d;
            rst_n_q      <= rst_n_d;
            ready_q      <= ready_d;
`ifdef PLL_RESET_SEQ_RETRY_EN
            tmo_cnt_q    <= tmo_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            retry_q      <= retry_d;
`endif
        end
    end

    assign rst_out       = rst_q;
    assign rst_n_out     = rst_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_cnt_q;
`ifdef PLL_RESET_SEQ_RETRY_EN
    assign pll_retry_out = retry_q;
`else
    assign pll_retry_out = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: latency-based reference model feeding a scoreboard, plus segment table.
// Build with PLL_RESET_SEQ_RETRY_EN defined to exercise the retry pulse.
module tb_pll_reset_seq;

    localparam int SS   = 2;
    localparam int LS   = 8;
    localparam int RH   = 4;
    localparam int CW   = 4;
    localparam int TMO  = 32;
    localparam int RP   = 3;
    localparam int QUAL = LS + RH;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PLL_RESET_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic          clock_in = 1'b0;
    logic          rst_in;
    logic          locked_in;
    logic          rst_out;
    logic          rst_n_out;
    logic          ready;
    logic [CW-1:0] lock_loss_cnt;
    logic          pll_retry_out;

    always #5 clock_in = ~clock_in;

    pll_reset_seq #(
        .SYNC_STAGES(SS),
        .LOCK_STABLE(LS),
        .RST_HOLD   (RH),
        .CNT_W      (CW),
        .TIMEOUT    (TMO),
        .RETRY_PULSE(RP)
    ) dut (
        .clock_in     (clock_in),
        .rst_in       (rst_in),
        .locked_in    (locked_in),
        .rst_out      (rst_out),
        .rst_n_out    (rst_n_out),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .pll_retry_out(pll_retry_out)
    );

    typedef struct {
        bit rst;
        int cnt;
        bit retry;
    } exp_t;

    typedef struct {
        bit lock;
        int n;
        bit rst;
        bit rdy;
        int cnt;
    } seg_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: reset is released once lock was seen on QUAL consecutive edges, SS edges earlier.
    int hi_run, h0, h1, h2, m_cnt;
    bit m_rst;
    int retry_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hi_run = 0; h0 = 0; h1 = 0; h2 = 0;
        m_cnt  = 0;
        m_rst  = 1'b1;
    endtask

    task automatic step(input bit lock, input bit exp_retry);
        exp_t e;
        locked_in = lock;
        if (!rst_in) begin
            model_reset();
        end else begin
            hi_run = lock ? hi_run + 1 : 0;
            h2 = h1; h1 = h0; h0 = hi_run;
            if (!m_rst && h2 < QUAL) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            m_rst = (h2 < QUAL);
        end
        e.rst   = m_rst;
        e.cnt   = m_cnt;
        e.retry = exp_retry;
        sb_q.push_back(e);
        @(posedge clock_in);
        #1;
        e = sb_q.pop_front();
        chk("rst_out", int'(rst_out), int'(e.rst));
        chk("rst_n_out", int'(rst_n_out), int'(!e.rst));
        chk("ready", int'(ready), int'(!e.rst));
        chk("lock_loss_cnt", int'(lock_loss_cnt), e.cnt);
        chk("pll_retry_out", int'(pll_retry_out), int'(e.retry));
        if (pll_retry_out) retry_seen++;
    endtask

    initial begin
        seg_t segs[10];
        bit   er;
        segs[0] = '{1'b0, 2,  1'b0, 1'b1, 0};
        segs[1] = '{1'b0, 1,  1'b1, 1'b0, 1};
        segs[2] = '{1'b0, 3,  1'b1, 1'b0, 1};
        segs[3] = '{1'b1, 13, 1'b1, 1'b0, 1};
        segs[4] = '{1'b1, 1,  1'b0, 1'b1, 1};
        segs[5] = '{1'b0, 5,  1'b1, 1'b0, 2};
        segs[6] = '{1'b1, 4,  1'b1, 1'b0, 2};
        segs[7] = '{1'b0, 1,  1'b1, 1'b0, 2};
        segs[8] = '{1'b1, 13, 1'b1, 1'b0, 2};
        segs[9] = '{1'b1, 1,  1'b0, 1'b1, 2};

        retry_seen = 0;
        rst_in     = 1'b1;
        locked_in  = 1'b0;
        model_reset();
        #2 rst_in = 1'b0;
        #1;
        chk("reset_rst_out", int'(rst_out), 1);
        chk("reset_rst_n_out", int'(rst_n_out), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_cnt", int'(lock_loss_cnt), 0);

        // Release latency: reset over edges 1..5, lock seen first at edge 10, release at edge 23.
        repeat (5) step(1'b0, 1'b0);
        rst_in = 1'b1;
        repeat (4) step(1'b0, 1'b0);
        repeat (13) step(1'b1, 1'b0);
        chk("release_e22_rst", int'(rst_out), 1);
        step(1'b1, 1'b0);
        chk("release_e23_rst", int'(rst_out), 0);
        chk("release_e23_ready", int'(ready), 1);
        chk("release_e23_cnt", int'(lock_loss_cnt), 0);

        // Loss in RUN, re-lock, then a one-cycle glitch while qualifying.
        for (int s = 0; s < 10; s++) begin
            repeat (segs[s].n) step(segs[s].lock, 1'b0);
            chk("seg_rst", int'(rst_out), int'(segs[s].rst));
            chk("seg_ready", int'(ready), int'(segs[s].rdy));
            chk("seg_cnt", int'(lock_loss_cnt), segs[s].cnt);
        end

        // Saturation of the loss counter.
        for (int i = 0; i < 20; i++) begin
            repeat (3) step(1'b0, 1'b0);
            repeat (14) step(1'b1, 1'b0);
            chk("sat_iter_cnt", int'(lock_loss_cnt), (3 + i > CMAX) ? CMAX : 3 + i);
        end
        chk("sat_final_cnt", int'(lock_loss_cnt), CMAX);
        chk("sat_final_ready", int'(ready), 1);

        // Asynchronous reset while in HOLD.
        repeat (3) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        #3 rst_in = 1'b0;
        #1;
        chk("async_hold_rst", int'(rst_out), 1);
        chk("async_hold_rst_n", int'(rst_n_out), 0);
        chk("async_hold_cnt", int'(lock_loss_cnt), 0);
        model_reset();
        repeat (2) step(1'b1, 1'b0);
        rst_in = 1'b1;
        repeat (13) step(1'b1, 1'b0);
        chk("restart_e13_rst", int'(rst_out), 1);
        step(1'b1, 1'b0);
        chk("restart_e14_rst", int'(rst_out), 0);

        // Asynchronous reset while in RUN must raise rst_out without a clock edge.
        #3 rst_in = 1'b0;
        #1;
        chk("async_run_rst", int'(rst_out), 1);
        chk("async_run_ready", int'(ready), 0);
        model_reset();
        step(1'b0, 1'b0);

        // Lock never arrives: retry pulses at edge 32, period TMO+RP.
        rst_in     = 1'b1;
        retry_seen = 0;
        for (int k = 1; k <= 110; k++) begin
            er = RETRY_EN && (k >= TMO) && (((k - TMO) % (TMO + RP)) < RP);
            step(1'b0, er);
        end
        chk("retry_high_cycles", retry_seen, RETRY_EN ? 3 * RP : 0);
        chk("retry_rst_held", int'(rst_out), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
